// File: rtl/frame_swap_ctrl.sv
// frame_swap_ctrl: double-buffered frame sequencer and single-port SRAM arbiter.
// The VGA reader always wins the SRAM port. The draw engine may only write the
// back buffer while a frame is being drawn. Buffers swap on a vsync that follows
// the draw engine's completion report.
module frame_swap_ctrl #(
    parameter int ADDR_W   = 18,
    parameter int DATA_W   = 16,
    parameter int READ_LAT = 2,
    parameter int DROP_W   = 8
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                VGA_VS,
    input  logic                draw_done,
    output logic                frame_start,
    output logic                display_buf,
    output logic                swap_pending,
    output logic [DROP_W-1:0]   drop_count,
    input  logic                rd_req,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic                rd_gnt,
    output logic                rd_valid,
    output logic [DATA_W-1:0]   rd_data,
    input  logic                wr_req,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
    output logic                wr_gnt,
    output logic [ADDR_W:0]     sram_addr,
    output logic                sram_we_n,
    output logic                sram_oe_n,
    output logic [DATA_W-1:0]   sram_wdata,
    input  logic [DATA_W-1:0]   sram_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAW  = 2'd1,
        ST_READY = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;
    logic                prev_vs_r;
    logic                vs_fall_s;
    logic                swap_s;
    logic                start_s;
    logic                drop_inc_s;
    logic [READ_LAT-1:0] rd_tag_r;

    // A vsync begins on the high-to-low transition of the active-low sync.
    always_comb begin
        vs_fall_s = prev_vs_r & ~VGA_VS;
    end

    // Remember the previous sync level for edge detection.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            prev_vs_r <= 1'b1;
        end else begin
            prev_vs_r <= VGA_VS;
        end
    end

    // Frame sequencing: decide the next phase and whether this vsync swaps, starts or drops.
    always_comb begin
        state_nxt_s = state_r;
        swap_s      = 1'b0;
        start_s     = 1'b0;
        drop_inc_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (vs_fall_s) begin
                    state_nxt_s = ST_DRAW;
                    start_s     = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_DRAW: begin
                if (vs_fall_s && draw_done) begin
                    // Completion and vsync coincide: swap now and keep drawing the next frame.
                    state_nxt_s = ST_DRAW;
                    swap_s      = 1'b1;
                    start_s     = 1'b1;
                end else if (vs_fall_s) begin
                    state_nxt_s = ST_DRAW;
                    drop_inc_s  = 1'b1;
                end else if (draw_done) begin
                    state_nxt_s = ST_READY;
                end else begin
                    state_nxt_s = ST_DRAW;
                end
            end
            ST_READY: begin
                if (vs_fall_s) begin
                    state_nxt_s = ST_DRAW;
                    swap_s      = 1'b1;
                    start_s     = 1'b1;
                end else begin
                    state_nxt_s = ST_READY;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Frame state and frame-level outputs, all registered.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_r      <= ST_IDLE;
            display_buf  <= 1'b0;
            frame_start  <= 1'b0;
            swap_pending <= 1'b0;
            drop_count   <= {DROP_W{1'b0}};
        end else begin
            state_r      <= state_nxt_s;
            display_buf  <= display_buf ^ swap_s;
            frame_start  <= start_s;
            swap_pending <= (state_nxt_s == ST_READY);
            if (drop_inc_s && !(&drop_count)) begin
                drop_count <= drop_count + {{(DROP_W-1){1'b0}}, 1'b1};
            end else begin
                drop_count <= drop_count;
            end
        end
    end

    // Fixed-priority arbitration; writes only while the back buffer is being drawn.
    always_comb begin
        rd_gnt = rd_req;
        wr_gnt = wr_req & ~rd_req & (state_r == ST_DRAW);
    end

    // Register the SRAM pins from the granted access; buffer bit is taken in the grant cycle.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            sram_addr  <= {(ADDR_W+1){1'b0}};
            sram_we_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
            sram_wdata <= {DATA_W{1'b0}};
        end else if (rd_gnt) begin
            sram_addr  <= {display_buf, rd_addr};
            sram_we_n  <= 1'b1;
            sram_oe_n  <= 1'b0;
        end else if (wr_gnt) begin
            sram_addr  <= {~display_buf, wr_addr};
            sram_wdata <= wr_data;
            sram_we_n  <= 1'b0;
            sram_oe_n  <= 1'b1;
        end else begin
            sram_we_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
        end
    end

    // Track read grants through the SRAM latency and capture the returned data.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            rd_tag_r <= {READ_LAT{1'b0}};
            rd_valid <= 1'b0;
            rd_data  <= {DATA_W{1'b0}};
        end else begin
            rd_tag_r[0] <= rd_gnt;
            for (int i = 1; i < READ_LAT; i++) begin
                rd_tag_r[i] <= rd_tag_r[i-1];
            end
            rd_valid <= rd_tag_r[READ_LAT-1];
            if (rd_tag_r[READ_LAT-1]) begin
                rd_data <= sram_rdata;
            end else begin
                rd_data <= rd_data;
            end
        end
    end

endmodule

// File: tb/tb_frame_swap_ctrl.sv
// Testbench for frame_swap_ctrl: random and directed stimulus, compared against a
// frame-level reference model, with read returns checked by a scoreboard monitor.
module tb_frame_swap_ctrl;

    localparam int AW = 18;
    localparam int DW = 16;
    localparam int RL = 2;

    logic          Clk = 1'b0;
    logic          Reset = 1'b0;
    logic          VGA_VS = 1'b1;
    logic          draw_done = 1'b0;
    logic          rd_req = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic          wr_req = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic [DW-1:0] sram_rdata;
    logic [AW:0]   sram_addr_d = '0;

    logic          frame_start, display_buf, swap_pending, rd_gnt, rd_valid, wr_gnt;
    logic          sram_we_n, sram_oe_n;
    logic [7:0]    drop_count;
    logic [DW-1:0] rd_data, sram_wdata;
    logic [AW:0]   sram_addr;

    logic          frame_start2, display_buf2, swap_pending2, rd_gnt2, rd_valid2, wr_gnt2;
    logic          sram_we_n2, sram_oe_n2;
    logic [1:0]    drop_count2;
    logic [DW-1:0] rd_data2, sram_wdata2;
    logic [AW:0]   sram_addr2;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } exp_t;
    exp_t exp_q[$];

    // Reference model of the frame cycle
    logic          m_prev_vs = 1'b1;
    logic          m_started = 1'b0;
    logic          m_ready = 1'b0;
    logic          m_disp = 1'b0;
    logic          m_fs = 1'b0;
    int            m_drops = 0;
    logic          e_we_n = 1'b1;
    logic          e_oe_n = 1'b1;
    logic [AW:0]   e_addr = '0;
    logic [DW-1:0] e_wdata = '0;
    logic          last_wgnt = 1'b0;

    frame_swap_ctrl #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(RL), .DROP_W(8)) u_dut (
        .Clk(Clk), .Reset(Reset), .VGA_VS(VGA_VS), .draw_done(draw_done),
        .frame_start(frame_start), .display_buf(display_buf), .swap_pending(swap_pending),
        .drop_count(drop_count), .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
        .rd_valid(rd_valid), .rd_data(rd_data), .wr_req(wr_req), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_gnt(wr_gnt), .sram_addr(sram_addr), .sram_we_n(sram_we_n),
        .sram_oe_n(sram_oe_n), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    frame_swap_ctrl #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(RL), .DROP_W(2)) u_dut2 (
        .Clk(Clk), .Reset(Reset), .VGA_VS(VGA_VS), .draw_done(draw_done),
        .frame_start(frame_start2), .display_buf(display_buf2), .swap_pending(swap_pending2),
        .drop_count(drop_count2), .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt2),
        .rd_valid(rd_valid2), .rd_data(rd_data2), .wr_req(wr_req), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_gnt(wr_gnt2), .sram_addr(sram_addr2), .sram_we_n(sram_we_n2),
        .sram_oe_n(sram_oe_n2), .sram_wdata(sram_wdata2), .sram_rdata(sram_rdata)
    );

    // Deterministic SRAM contents as a function of the full address.
    function automatic logic [DW-1:0] mem_f(input logic [AW:0] a);
        return 16'((a[15:0] * 16'd7) ^ {a[18:16], 13'h0ABC});
    endfunction

    always #5 Clk = ~Clk;

    // SRAM model: data for an address presented in one cycle appears in the next.
    always @(posedge Clk) sram_addr_d <= sram_addr;
    assign sram_rdata = mem_f(sram_addr_d);

    // Cycle counter used for read latency expectations.
    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every read return must match the oldest expectation in data and cycle.
    always @(negedge Clk) begin
        exp_t e;
        if (rd_valid) begin
            if (exp_q.size() == 0) begin
                chk("rd_valid_spurious", 32'(rd_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("rd_data", 32'(rd_data), 32'(e.data));
                chk("rd_latency", 32'(cyc), 32'(e.due));
            end
        end else if (exp_q.size() != 0 && exp_q[0].due < cyc) begin
            e = exp_q.pop_front();
            chk("rd_valid_missing", 32'(rd_valid), 32'd1);
        end
    end

    // One clock cycle: apply inputs, check outputs, advance the reference model.
    task automatic step(input logic vs, input logic dn, input logic rq, input logic [AW-1:0] ra,
                        input logic wq, input logic [AW-1:0] wa, input logic [DW-1:0] wd);
        logic vsf;
        logic wg;
        logic rst_now;
        exp_t e;
        VGA_VS = vs; draw_done = dn; rd_req = rq; rd_addr = ra;
        wr_req = wq; wr_addr = wa; wr_data = wd;
        @(negedge Clk);
        chk("display_buf", 32'(display_buf), 32'(m_disp));
        chk("frame_start", 32'(frame_start), 32'(m_fs));
        chk("swap_pending", 32'(swap_pending), 32'(m_ready));
        chk("drop_count", 32'(drop_count), 32'((m_drops > 255) ? 255 : m_drops));
        chk("drop_count_w2", 32'(drop_count2), 32'((m_drops > 3) ? 3 : m_drops));
        chk("sram_we_n", 32'(sram_we_n), 32'(e_we_n));
        chk("sram_oe_n", 32'(sram_oe_n), 32'(e_oe_n));
        chk("sram_addr", 32'(sram_addr), 32'(e_addr));
        chk("sram_wdata", 32'(sram_wdata), 32'(e_wdata));
        wg = wq & ~rq & m_started & ~m_ready;
        chk("rd_gnt", 32'(rd_gnt), 32'(rq));
        chk("wr_gnt", 32'(wr_gnt), 32'(wg));
        last_wgnt = wg;
        rst_now = ~Reset;
        if (rst_now) begin
            m_prev_vs = 1'b1; m_started = 1'b0; m_ready = 1'b0; m_disp = 1'b0;
            m_fs = 1'b0; m_drops = 0;
            e_we_n = 1'b1; e_oe_n = 1'b1; e_addr = '0; e_wdata = '0;
        end else begin
            if (rq) begin
                e_addr = {m_disp, ra}; e_oe_n = 1'b0; e_we_n = 1'b1;
                e.data = mem_f({m_disp, ra});
                e.due = cyc + RL + 1;
                exp_q.push_back(e);
            end else if (wg) begin
                e_addr = {~m_disp, wa}; e_wdata = wd; e_we_n = 1'b0; e_oe_n = 1'b1;
            end else begin
                e_we_n = 1'b1; e_oe_n = 1'b1;
            end
            vsf = m_prev_vs & ~vs;
            m_prev_vs = vs;
            m_fs = 1'b0;
            if (vsf) begin
                if (!m_started) begin
                    m_started = 1'b1; m_fs = 1'b1;
                end else if (m_ready || dn) begin
                    m_disp = ~m_disp; m_fs = 1'b1; m_ready = 1'b0;
                end else begin
                    m_drops++;
                end
            end else if (dn && m_started) begin
                m_ready = 1'b1;
            end
        end
        @(posedge Clk);
        #1;
        if (rst_now) exp_q.delete();
    endtask

    task automatic idle(input int n, input logic vs);
        for (int i = 0; i < n; i++) step(vs, 1'b0, 1'b0, '0, 1'b0, '0, '0);
    endtask

    initial begin
        logic          vs_c;
        logic          h_wq;
        logic [AW-1:0] h_wa;
        logic [DW-1:0] h_wd;
        h_wq = 1'b0; h_wa = '0; h_wd = '0;
        @(posedge Clk);
        #1;
        // Reset, then idle with writes blocked
        idle(2, 1'b1);
        Reset = 1'b1;
        step(1'b1, 1'b0, 1'b0, '0, 1'b1, 18'd7, 16'h1111);
        idle(1, 1'b1);
        // First vsync starts drawing; write lands in the back buffer
        step(1'b0, 1'b0, 1'b0, '0, 1'b0, '0, '0);
        step(1'b0, 1'b0, 1'b0, '0, 1'b1, 18'd5, 16'hABCD);
        idle(2, 1'b1);
        // Completion then vsync swaps
        step(1'b1, 1'b1, 1'b0, '0, 1'b0, '0, '0);
        idle(2, 1'b1);
        idle(1, 1'b0);
        idle(2, 1'b1);
        // Three missed vsyncs
        for (int i = 0; i < 3; i++) begin
            idle(1, 1'b0);
            idle(2, 1'b1);
        end
        // Completion coincident with vsync
        step(1'b0, 1'b1, 1'b0, '0, 1'b0, '0, '0);
        idle(2, 1'b1);
        // Read has priority over a pending write
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, AW'(i), 1'b1, 18'd9, 16'h5555);
        step(1'b1, 1'b0, 1'b0, '0, 1'b1, 18'd9, 16'h5555);
        idle(6, 1'b1);
        // Long run of missed vsyncs saturates both counters
        for (int i = 0; i < 260; i++) begin
            idle(1, 1'b0);
            idle(1, 1'b1);
        end
        // Reset while reads are in flight discards them
        step(1'b1, 1'b0, 1'b1, 18'd100, 1'b0, '0, '0);
        step(1'b1, 1'b0, 1'b1, 18'd101, 1'b0, '0, '0);
        Reset = 1'b0;
        idle(2, 1'b1);
        Reset = 1'b1;
        idle(6, 1'b1);
        // Randomized traffic with periodic vsync
        for (int c = 0; c < 1500; c++) begin
            vs_c = ((c % 37) < 3) ? 1'b0 : 1'b1;
            if (!h_wq && ($urandom_range(0, 2) == 0)) begin
                h_wq = 1'b1; h_wa = AW'($urandom); h_wd = DW'($urandom);
            end
            step(vs_c, ($urandom_range(0, 24) == 0), 1'($urandom_range(0, 1)), AW'($urandom),
                 h_wq, h_wa, h_wd);
            if (last_wgnt) h_wq = 1'b0;
        end
        idle(8, 1'b1);
        chk("read_queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
